// File: rtl/pre_if_stage.sv
// Pre-IF stage: owns the fetch PC, issues sram-like instruction address
// requests and hands each accepted (or ADEF-marked) PC to the IF stage.
//
// state  | meaning
// S_IDLE | first cycle after reset, no request
// S_RUN  | fetching; requests issued while the PC is word aligned
// S_STOP | misaligned PC handed over as ADEF, frozen until a redirect
module pre_if_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        fs_allowin,
    output logic        pfs_to_fs_valid,
    output logic [32:0] pfs_to_fs_bus,
    output logic        pfs_discard,
    input  logic [32:0] br_bus,
    input  logic        excp_flush,
    input  logic        ertn_flush,
    input  logic [31:0] csr_era,
    input  logic [31:0] csr_eentry,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    localparam logic [31:0] PC_RESET = 32'h1c00_0000;

    state_t      r_fsm;
    logic [31:0] r_pc;
    logic        r_hold;
    logic        r_redir_pend;
    logic [31:0] r_redir_pc;
    logic        r_out_valid;
    logic [32:0] r_out_bus;

    logic        w_br_taken;
    logic [31:0] w_br_target;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_out_free;
    logic        w_pc_aligned;
    logic        w_hs;
    logic        w_load_ok;
    logic        w_load_adef;

    assign w_br_taken   = br_bus[32];
    assign w_br_target  = br_bus[31:0];
    assign w_redirect   = excp_flush | ertn_flush | w_br_taken;
    assign w_target     = excp_flush ? csr_eentry :
                          ertn_flush ? csr_era    : w_br_target;
    assign w_out_free   = ~r_out_valid | fs_allowin;
    assign w_pc_aligned = (r_pc[1:0] == 2'b00);

    // A pending request (hold) keeps req high regardless of IF back-pressure
    assign inst_sram_req = (r_fsm == S_RUN) & w_pc_aligned & (r_hold | w_out_free);
    assign w_hs          = inst_sram_req & inst_sram_addr_ok;

    // A handshake on a wrong-path address is accepted by the sram but its
    // data must be dropped downstream, hence the discard pulse.
    assign pfs_discard = w_hs & (w_redirect | r_redir_pend);
    assign w_load_ok   = w_hs & ~w_redirect & ~r_redir_pend;
    assign w_load_adef = (r_fsm == S_RUN) & ~w_pc_aligned & ~r_hold & w_out_free & ~w_redirect;

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'h0;
    assign inst_sram_addr  = r_pc;

    assign pfs_to_fs_valid = r_out_valid;
    assign pfs_to_fs_bus   = r_out_bus;

    // Fetch FSM, PC/redirect bookkeeping and the output register to IF
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm        <= S_IDLE;
            r_pc         <= PC_RESET;
            r_hold       <= 1'b0;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= 32'h0;
            r_out_valid  <= 1'b0;
            r_out_bus    <= 33'h0;
        end else begin
            r_hold <= inst_sram_req & ~inst_sram_addr_ok;

            // Redirect wins over both a new load and consumption by IF
            if (w_redirect) begin
                r_out_valid <= 1'b0;
            end else if (w_load_ok | w_load_adef) begin
                r_out_valid <= 1'b1;
            end else if (fs_allowin) begin
                r_out_valid <= 1'b0;
            end

            case (r_fsm)
                S_IDLE: begin
                    r_fsm <= S_RUN;
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end
                end
                S_RUN: begin
                    if (w_hs) begin
                        if (w_redirect) begin
                            r_pc <= w_target;
                        end else if (r_redir_pend) begin
                            r_pc <= r_redir_pc;
                        end else begin
                            r_pc      <= r_pc + 32'd4;
                            r_out_bus <= {1'b0, r_pc};
                        end
                        r_redir_pend <= 1'b0;
                    end else if (inst_sram_req) begin
                        // Address not yet accepted: PC must stay put, so
                        // remember the newest redirect for after the handshake
                        if (w_redirect) begin
                            r_redir_pc   <= w_target;
                            r_redir_pend <= 1'b1;
                        end
                    end else if (w_redirect) begin
                        r_pc <= w_target;
                    end else if (w_load_adef) begin
                        r_out_bus <= {1'b1, r_pc};
                        r_fsm     <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_redirect) begin
                        r_pc  <= w_target;
                        r_fsm <= S_RUN;
                    end
                end
                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pre_if_stage.sv
module tb_pre_if_stage;

    logic        clk;
    logic        reset;
    logic        fs_allowin;
    logic        pfs_to_fs_valid;
    logic [32:0] pfs_to_fs_bus;
    logic        pfs_discard;
    logic [32:0] br_bus;
    logic        excp_flush;
    logic        ertn_flush;
    logic [31:0] csr_era;
    logic [31:0] csr_eentry;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;

    pre_if_stage dut (
        .clk               (clk),
        .reset             (reset),
        .fs_allowin        (fs_allowin),
        .pfs_to_fs_valid   (pfs_to_fs_valid),
        .pfs_to_fs_bus     (pfs_to_fs_bus),
        .pfs_discard       (pfs_discard),
        .br_bus            (br_bus),
        .excp_flush        (excp_flush),
        .ertn_flush        (ertn_flush),
        .csr_era           (csr_era),
        .csr_eentry        (csr_eentry),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          fa;
        bit          aok;
        bit          brt;
        logic [31:0] btgt;
        bit          exc;
        bit          ertn;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_disc;
        bit          e_val;
        logic [32:0] e_bus;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic vec(input bit rst, input bit fa, input bit aok, input bit brt,
                       input logic [31:0] btgt, input bit exc, input bit ertn,
                       input bit e_req, input logic [31:0] e_addr, input bit e_disc,
                       input bit e_val, input logic [32:0] e_bus);
        vec_t v;
        v.rst = rst; v.fa = fa; v.aok = aok; v.brt = brt; v.btgt = btgt;
        v.exc = exc; v.ertn = ertn; v.e_req = e_req; v.e_addr = e_addr;
        v.e_disc = e_disc; v.e_val = e_val; v.e_bus = e_bus;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int cyc;

        reset             = 1'b1;
        fs_allowin        = 1'b0;
        br_bus            = 33'h0;
        excp_flush        = 1'b0;
        ertn_flush        = 1'b0;
        csr_era           = 32'h1c00_4000;
        csr_eentry        = 32'h1c00_8000;
        inst_sram_addr_ok = 1'b0;

        //   rst fa aok brt btgt          exc ertn | req addr          disc val bus
        // reset release, back-to-back fetch
        vec(1, 1, 1, 0, 32'h0,         0, 0,   0, 32'h1c000000, 0, 0, 33'h0);
        vec(0, 1, 1, 0, 32'h0,         0, 0,   0, 32'h1c000000, 0, 0, 33'h0);
        vec(0, 1, 1, 0, 32'h0,         0, 0,   1, 32'h1c000000, 0, 0, 33'h0);
        vec(0, 1, 1, 0, 32'h0,         0, 0,   1, 32'h1c000004, 0, 1, {1'b0, 32'h1c000000});
        vec(0, 1, 1, 0, 32'h0,         0, 0,   1, 32'h1c000008, 0, 1, {1'b0, 32'h1c000004});
        // reset mid-request, addr_ok low 3 cycles with a branch in the middle
        vec(1, 1, 0, 0, 32'h0,         0, 0,   0, 32'h1c000000, 0, 0, 33'h0);
        vec(0, 1, 0, 0, 32'h0,         0, 0,   0, 32'h1c000000, 0, 0, 33'h0);
        vec(0, 1, 0, 0, 32'h0,         0, 0,   1, 32'h1c000000, 0, 0, 33'h0);
        vec(0, 1, 0, 1, 32'h1c000100,  0, 0,   1, 32'h1c000000, 0, 0, 33'h0);
        vec(0, 1, 0, 0, 32'h0,         0, 0,   1, 32'h1c000000, 0, 0, 33'h0);
        vec(0, 1, 1, 0, 32'h0,         0, 0,   1, 32'h1c000000, 1, 0, 33'h0);
        vec(0, 1, 1, 0, 32'h0,         0, 0,   1, 32'h1c000100, 0, 0, 33'h0);
        // IF back-pressure
        vec(0, 0, 1, 0, 32'h0,         0, 0,   0, 32'h1c000104, 0, 1, {1'b0, 32'h1c000100});
        vec(0, 0, 1, 0, 32'h0,         0, 0,   0, 32'h1c000104, 0, 1, {1'b0, 32'h1c000100});
        vec(0, 1, 1, 0, 32'h0,         0, 0,   1, 32'h1c000104, 0, 1, {1'b0, 32'h1c000100});
        // exception beats branch on a handshake
        vec(0, 1, 1, 1, 32'h1c000200,  1, 0,   1, 32'h1c000108, 1, 1, {1'b0, 32'h1c000104});
        vec(0, 1, 1, 0, 32'h0,         0, 0,   1, 32'h1c008000, 0, 0, 33'h0);
        // pending redirect overwritten before the handshake
        vec(0, 1, 0, 1, 32'h1c000300,  0, 1,   1, 32'h1c008004, 0, 1, {1'b0, 32'h1c008000});
        vec(0, 1, 0, 1, 32'h1c000400,  0, 0,   1, 32'h1c008004, 0, 0, 33'h0);
        vec(0, 1, 1, 0, 32'h0,         0, 0,   1, 32'h1c008004, 1, 0, 33'h0);
        vec(0, 1, 1, 0, 32'h0,         0, 0,   1, 32'h1c000400, 0, 0, 33'h0);
        // misaligned branch target -> ADEF, stop, exception restarts
        vec(0, 1, 1, 1, 32'h1c000102,  0, 0,   1, 32'h1c000404, 1, 1, {1'b0, 32'h1c000400});
        vec(0, 1, 1, 0, 32'h0,         0, 0,   0, 32'h1c000102, 0, 0, 33'h0);
        vec(0, 0, 1, 0, 32'h0,         0, 0,   0, 32'h1c000102, 0, 1, {1'b1, 32'h1c000102});
        vec(0, 1, 1, 0, 32'h0,         0, 0,   0, 32'h1c000102, 0, 1, {1'b1, 32'h1c000102});
        vec(0, 1, 1, 0, 32'h0,         0, 0,   0, 32'h1c000102, 0, 0, 33'h0);
        vec(0, 1, 1, 0, 32'h0,         1, 0,   0, 32'h1c000102, 0, 0, 33'h0);
        vec(0, 1, 1, 0, 32'h0,         0, 0,   1, 32'h1c008000, 0, 0, 33'h0);
        vec(0, 1, 1, 0, 32'h0,         0, 0,   1, 32'h1c008004, 0, 1, {1'b0, 32'h1c008000});
        // redirect while stalled by IF: immediate, no discard, clears valid
        vec(0, 0, 1, 0, 32'h0,         0, 0,   0, 32'h1c008008, 0, 1, {1'b0, 32'h1c008004});
        vec(0, 0, 1, 1, 32'h1c000500,  0, 0,   0, 32'h1c008008, 0, 1, {1'b0, 32'h1c008004});
        vec(0, 0, 1, 0, 32'h0,         0, 0,   1, 32'h1c000500, 0, 0, 33'h0);
        vec(0, 0, 1, 0, 32'h0,         0, 0,   0, 32'h1c000504, 0, 1, {1'b0, 32'h1c000500});

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            reset             = vecs[i].rst;
            fs_allowin        = vecs[i].fa;
            inst_sram_addr_ok = vecs[i].aok;
            br_bus            = {vecs[i].brt, vecs[i].btgt};
            excp_flush        = vecs[i].exc;
            ertn_flush        = vecs[i].ertn;
            @(negedge clk);
            chk($sformatf("v%0d req", i),  {32'h0, inst_sram_req},   {32'h0, vecs[i].e_req});
            chk($sformatf("v%0d addr", i), {1'b0, inst_sram_addr},   {1'b0, vecs[i].e_addr});
            chk($sformatf("v%0d disc", i), {32'h0, pfs_discard},     {32'h0, vecs[i].e_disc});
            chk($sformatf("v%0d val", i),  {32'h0, pfs_to_fs_valid}, {32'h0, vecs[i].e_val});
            if (vecs[i].e_val || vecs[i].rst)
                chk($sformatf("v%0d bus", i), pfs_to_fs_bus, vecs[i].e_bus);
            if (i == 0)
                chk("const_fields", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata[25:0]},
                    {1'b0, 2'b10, 4'b0000, 26'h0});
        end

        // Hand sequence: first request latency, ertn redirect, PC wrap-around
        @(posedge clk);
        #1;
        reset             = 1'b1;
        br_bus            = 33'h0;
        excp_flush        = 1'b0;
        ertn_flush        = 1'b0;
        fs_allowin        = 1'b1;
        inst_sram_addr_ok = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen  = 1'b0;
        cyc   = 0;
        while (!seen && cyc < 8) begin
            @(negedge clk);
            if (inst_sram_req) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: no request within 8 cycles, expected after 1");
        end else begin
            chk("first_req_latency", 33'(cyc), 33'd1);
            chk("first_req_addr", {1'b0, inst_sram_addr}, {1'b0, 32'h1c000000});
            ertn_flush = 1'b1;
            #1;
            chk("ertn_disc", {32'h0, pfs_discard}, 33'd1);
            @(posedge clk);
            #1;
            ertn_flush = 1'b0;
            @(negedge clk);
            chk("ertn_addr", {1'b0, inst_sram_addr}, {1'b0, 32'h1c004000});
            chk("ertn_val", {32'h0, pfs_to_fs_valid}, 33'd0);
            @(negedge clk);
            chk("era_bus", pfs_to_fs_bus, {1'b0, 32'h1c004000});
            chk("era_next", {1'b0, inst_sram_addr}, {1'b0, 32'h1c004004});
            csr_era    = 32'hffff_fffc;
            ertn_flush = 1'b1;
            @(posedge clk);
            #1;
            ertn_flush = 1'b0;
            @(negedge clk);
            chk("wrap_addr", {1'b0, inst_sram_addr}, {1'b0, 32'hffff_fffc});
            chk("wrap_req", {32'h0, inst_sram_req}, 33'd1);
            @(negedge clk);
            chk("wrap_next", {1'b0, inst_sram_addr}, 33'h0);
            chk("wrap_bus", pfs_to_fs_bus, {1'b0, 32'hffff_fffc});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
